// File: rtl/csr_file.sv
// Machine-mode CSR register file: address-decoded 64-bit CSRs with free-running cycle and retire counters.
// Optional define CSR_WRITE_BYPASS_EN forwards a same-cycle write to the combinational read port.
module csr_file (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_write_enable,
    input  logic [11:0] csr_dest_addr,
    input  logic [63:0] csr_write_data,
    input  logic        retire,
    input  logic [11:0] rd_addr,
    output logic [63:0] rd_data,
    output logic        rd_illegal,
    output logic        wr_illegal
);
    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MISA     = 12'h301;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_SATP     = 12'h180;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    localparam logic [63:0] MISA_VALUE   = 64'h8000_0000_0000_0100;
    localparam logic [63:0] MSTATUS_MASK = 64'h8000_000F_007F_FFEA;

    logic [63:0] mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip, satp;
    logic [63:0] mcycle, minstret;
    logic [63:0] wr_value;
    logic        wr_legal;

    function automatic logic is_writable(input logic [11:0] addr);
        case (addr)
            ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC, ADDR_MSCRATCH, ADDR_MEPC,
            ADDR_MCAUSE, ADDR_MTVAL, ADDR_MIP, ADDR_SATP,
            ADDR_MCYCLE, ADDR_MINSTRET: is_writable = 1'b1;
            default:                    is_writable = 1'b0;
        endcase
    endfunction

    // Value actually stored for a write to addr, after per-register field masking.
    function automatic logic [63:0] masked_value(input logic [11:0] addr, input logic [63:0] data);
        case (addr)
            ADDR_MSTATUS: masked_value = data & MSTATUS_MASK;
            ADDR_MTVEC:   masked_value = {data[63:2], 1'b0, data[0]};
            ADDR_MEPC:    masked_value = {data[63:2], 2'b00};
            default:      masked_value = data;
        endcase
    endfunction

    assign wr_legal = is_writable(csr_dest_addr);
    assign wr_value = masked_value(csr_dest_addr, csr_write_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            mstatus    <= '0;
            mie        <= '0;
            mtvec      <= '0;
            mscratch   <= '0;
            mepc       <= '0;
            mcause     <= '0;
            mtval      <= '0;
            mip        <= '0;
            satp       <= '0;
            mcycle     <= '0;
            minstret   <= '0;
            wr_illegal <= 1'b0;
        end else begin
            mcycle     <= mcycle + 64'd1;
            if (retire)
                minstret <= minstret + 64'd1;
            wr_illegal <= csr_write_enable && !wr_legal;
            // Placed after the increments so an explicit counter write wins.
            if (csr_write_enable) begin
                case (csr_dest_addr)
                    ADDR_MSTATUS:  mstatus  <= wr_value;
                    ADDR_MIE:      mie      <= wr_value;
                    ADDR_MTVEC:    mtvec    <= wr_value;
                    ADDR_MSCRATCH: mscratch <= wr_value;
                    ADDR_MEPC:     mepc     <= wr_value;
                    ADDR_MCAUSE:   mcause   <= wr_value;
                    ADDR_MTVAL:    mtval    <= wr_value;
                    ADDR_MIP:      mip      <= wr_value;
                    ADDR_SATP:     satp     <= wr_value;
                    ADDR_MCYCLE:   mcycle   <= wr_value;
                    ADDR_MINSTRET: minstret <= wr_value;
                    default:       ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data    = '0;
        rd_illegal = 1'b0;
        case (rd_addr)
            ADDR_MSTATUS:  rd_data = mstatus;
            ADDR_MISA:     rd_data = MISA_VALUE;
            ADDR_MIE:      rd_data = mie;
            ADDR_MTVEC:    rd_data = mtvec;
            ADDR_MSCRATCH: rd_data = mscratch;
            ADDR_MEPC:     rd_data = mepc;
            ADDR_MCAUSE:   rd_data = mcause;
            ADDR_MTVAL:    rd_data = mtval;
            ADDR_MIP:      rd_data = mip;
            ADDR_SATP:     rd_data = satp;
            ADDR_MCYCLE:   rd_data = mcycle;
            ADDR_MINSTRET: rd_data = minstret;
            ADDR_MHARTID:  rd_data = '0;
            default:       rd_illegal = 1'b1;
        endcase
`ifdef CSR_WRITE_BYPASS_EN
        // Forwarding is suppressed in reset because the write will be discarded.
        if (!reset && csr_write_enable && csr_dest_addr == rd_addr && wr_legal)
            rd_data = wr_value;
`endif
    end
endmodule
